instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_pc_reg.sv | 40 ++++
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// datapath widths and the sequential PC step.
package fetch_pkg;

    localparam int ADDR_WIDTH  = 64;
    localparam int INSTR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] PC_INCREMENT = 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    // Instructions are word aligned; any set low bit makes a target unusable.
    function automatic logic is_aligned(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: asynchronous reset to RESET_PC, sequential
// increment, and redirect load (load wins over increment).
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inc_en,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_value,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Next PC: redirect load, else step by one instruction (wraps at 2^64).
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_value;
        end else if (inc_en) begin
            pc_d = pc_q + PC_INCREMENT;
        end
    end

    // PC state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one memory read per instruction, presents the
// returned word to decode with its address, and follows redirects. A
// misaligned redirect (or, with FETCH_TIMEOUT_EN defined, a memory that never
// answers within MAX_WAIT cycles) parks the unit in a sticky fault until reset.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 64'h0,
    parameter int                    MAX_WAIT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_accept,
    output logic                   fetch_fault
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..255");
    end

    fetch_state_e           state_q, state_d;
    logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   fetch_fault_q, fetch_fault_d;

    logic                   pc_inc;
    logic                   pc_load;
    logic [ADDR_WIDTH-1:0]  pc;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    logic [7:0] wait_q, wait_d;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock      (clock),
        .reset      (reset),
        .inc_en     (pc_inc),
        .load_en    (pc_load),
        .load_value (branch_target),
        .pc         (pc)
    );

    // Next-state and datapath control; a redirect overrides any same-cycle
    // memory return or downstream accept.
    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = fetch_fault_q;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_d        = '0;
`endif
        if (state_q != ST_FAULT && branch_taken) begin
            instr_valid_d = 1'b0;
            if (is_aligned(branch_target)) begin
                pc_load = 1'b1;
                state_d = ST_REQ;
            end else begin
                fetch_fault_d = 1'b1;
                state_d       = ST_FAULT;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        instruction_d = mem_rdata;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                        pc_inc        = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        wait_d = wait_q + 8'd1;
                        if (wait_d == WAIT_LIMIT) begin
                            wait_d        = '0;
                            fetch_fault_d = 1'b1;
                            state_d       = ST_FAULT;
                        end
`endif
                    end
                end
                ST_HOLD: begin
                    if (instr_accept) begin
                        instr_valid_d = 1'b0;
                        state_d       = ST_REQ;
                    end
                end
                default: begin
                    instr_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Control and presentation registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instruction_q <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait-state counter; only non-zero while a request is outstanding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign mem_req     = (state_q == ST_REQ);
    assign mem_addr    = pc;
    assign instruction = instruction_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Inputs change 1 time unit after
// each rising edge and outputs are checked at the same point.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_accept = 1'b0;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit #(
        .RESET_PC (64'h0),
        .MAX_WAIT (15)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_accept  (instr_accept),
        .fetch_fault   (fetch_fault)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        mem_ready     = 1'b0;
        mem_rdata     = '0;
        branch_taken  = 1'b0;
        branch_target = '0;
        instr_accept  = 1'b0;
    endtask

    // Assert reset between edges, check the immediate effect, release, and
    // advance through IDLE so the unit is requesting from RESET_PC.
    task automatic do_reset(input string tag);
        clear_inputs();
        reset = 1'b1;
        #1;
        check_val({tag, "_rst_req"},   64'(mem_req), 64'd0);
        check_val({tag, "_rst_addr"},  mem_addr, 64'h0);
        check_val({tag, "_rst_valid"}, 64'(instr_valid), 64'd0);
        check_val({tag, "_rst_fault"}, 64'(fetch_fault), 64'd0);
        check_val({tag, "_rst_instr"}, 64'(instruction), 64'd0);
        check_val({tag, "_rst_ipc"},   instr_pc, 64'h0);
        tick();
        reset = 1'b0;
        check_val({tag, "_idle_req"}, 64'(mem_req), 64'd0);
        tick();
        check_val({tag, "_req_req"},  64'(mem_req), 64'd1);
        check_val({tag, "_req_addr"}, mem_addr, 64'h0);
    endtask

    initial begin
        // Streaming: ready and accept every cycle -> addresses 0, 4, 8.
        do_reset("init");
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("stream%0d_addr", i), mem_addr, 64'(4 * i));
            check_val($sformatf("stream%0d_req", i), 64'(mem_req), 64'd1);
            check_val($sformatf("stream%0d_novalid", i), 64'(instr_valid), 64'd0);
            mem_ready    = 1'b1;
            instr_accept = 1'b1;
            mem_rdata    = 32'hA000_0000 + 32'(i);
            tick();
            check_val($sformatf("stream%0d_valid", i), 64'(instr_valid), 64'd1);
            check_val($sformatf("stream%0d_instr", i), 64'(instruction), 64'(32'hA000_0000 + 32'(i)));
            check_val($sformatf("stream%0d_ipc", i), instr_pc, 64'(4 * i));
            check_val($sformatf("stream%0d_hold_req", i), 64'(mem_req), 64'd0);
            tick();
        end

        // Slow memory: three wait cycles, then data.
        do_reset("slow");
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("slow%0d_req", i), 64'(mem_req), 64'd1);
            check_val($sformatf("slow%0d_addr", i), mem_addr, 64'h0);
            check_val($sformatf("slow%0d_novalid", i), 64'(instr_valid), 64'd0);
            tick();
        end
        check_val("slow3_req", 64'(mem_req), 64'd1);
        check_val("slow3_addr", mem_addr, 64'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hB0B0_B0B0;
        tick();
        mem_ready = 1'b0;
        check_val("slow_valid", 64'(instr_valid), 64'd1);
        check_val("slow_instr", 64'(instruction), 64'h0000_0000_B0B0_B0B0);
        check_val("slow_ipc", instr_pc, 64'h0);

        // Back-pressure in HOLD, with stray memory returns that must be ignored.
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hDEAD_0000 + 32'(i);
            tick();
            check_val($sformatf("hold%0d_valid", i), 64'(instr_valid), 64'd1);
            check_val($sformatf("hold%0d_instr", i), 64'(instruction), 64'h0000_0000_B0B0_B0B0);
            check_val($sformatf("hold%0d_ipc", i), instr_pc, 64'h0);
            check_val($sformatf("hold%0d_req", i), 64'(mem_req), 64'd0);
        end
        mem_ready    = 1'b0;
        instr_accept = 1'b1;
        tick();
        instr_accept = 1'b0;
        check_val("hold_done_valid", 64'(instr_valid), 64'd0);
        check_val("hold_done_req", 64'(mem_req), 64'd1);
        check_val("hold_done_addr", mem_addr, 64'h4);

        // Redirect colliding with a memory return: the old word is dropped.
        mem_ready     = 1'b1;
        mem_rdata     = 32'hC0C0_C0C0;
        branch_taken  = 1'b1;
        branch_target = 64'h100;
        tick();
        clear_inputs();
        check_val("br_req_valid", 64'(instr_valid), 64'd0);
        check_val("br_req_req", 64'(mem_req), 64'd1);
        check_val("br_req_addr", mem_addr, 64'h100);
        mem_ready = 1'b1;
        mem_rdata = 32'hD0D0_D0D0;
        tick();
        mem_ready = 1'b0;
        check_val("br_tgt_valid", 64'(instr_valid), 64'd1);
        check_val("br_tgt_instr", 64'(instruction), 64'h0000_0000_D0D0_D0D0);
        check_val("br_tgt_ipc", instr_pc, 64'h100);

        // Redirect from HOLD beats a same-cycle accept.
        instr_accept  = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 64'h200;
        tick();
        clear_inputs();
        check_val("br_hold_valid", 64'(instr_valid), 64'd0);
        check_val("br_hold_addr", mem_addr, 64'h200);
        check_val("br_hold_req", 64'(mem_req), 64'd1);

        // PC wrap: fetch from the last word of the address space.
        branch_taken  = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        clear_inputs();
        check_val("wrap_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ready = 1'b0;
        check_val("wrap_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("wrap_next_addr", mem_addr, 64'h0);
        instr_accept = 1'b1;
        tick();
        instr_accept = 1'b0;
        check_val("wrap_req", 64'(mem_req), 64'd1);
        check_val("wrap_req_addr", mem_addr, 64'h0);

        // Misaligned redirect: sticky fault, PC kept, everything ignored.
        branch_taken  = 1'b1;
        branch_target = 64'h300;
        tick();
        branch_target = 64'h102;
        tick();
        check_val("mis_fault", 64'(fetch_fault), 64'd1);
        check_val("mis_req", 64'(mem_req), 64'd0);
        check_val("mis_valid", 64'(instr_valid), 64'd0);
        check_val("mis_pc_kept", mem_addr, 64'h300);
        for (int i = 0; i < 5; i++) begin
            branch_taken  = 1'b1;
            branch_target = 64'h400;
            mem_ready     = 1'b1;
            instr_accept  = 1'b1;
            tick();
            check_val($sformatf("fault%0d_sticky", i), 64'(fetch_fault), 64'd1);
            check_val($sformatf("fault%0d_req", i), 64'(mem_req), 64'd0);
            check_val($sformatf("fault%0d_valid", i), 64'(instr_valid), 64'd0);
            check_val($sformatf("fault%0d_addr", i), mem_addr, 64'h300);
        end
        do_reset("unfault");

        // Memory that never answers.
`ifdef FETCH_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            tick();
            check_val($sformatf("to%0d_req", i), 64'(mem_req), 64'd1);
            check_val($sformatf("to%0d_nofault", i), 64'(fetch_fault), 64'd0);
        end
        tick();
        check_val("to_fault", 64'(fetch_fault), 64'd1);
        check_val("to_req", 64'(mem_req), 64'd0);
        do_reset("after_to");
`else
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check_val("nto_req", 64'(mem_req), 64'd1);
        check_val("nto_nofault", 64'(fetch_fault), 64'd0);
        check_val("nto_addr", mem_addr, 64'h0);
`endif

        // Reset pulse mid-wait drops the request without a clock edge.
        tick();
        tick();
        check_val("midwait_req", 64'(mem_req), 64'd1);
        reset = 1'b1;
        #1;
        check_val("midwait_drop", 64'(mem_req), 64'd0);
        #1;
        reset = 1'b0;
        check_val("midwait_addr", mem_addr, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
